// File: rtl/lkh_route_pkg.sv
// Shared constants for the look-ahead route unit: one-hot port codes,
// topology/route-name strings, cache entry layout and a width helper.
package lkh_route_pkg;

  localparam logic [4:0] P_LOCAL = 5'b00001;
  localparam logic [4:0] P_EAST  = 5'b00010;
  localparam logic [4:0] P_NORTH = 5'b00100;
  localparam logic [4:0] P_WEST  = 5'b01000;
  localparam logic [4:0] P_SOUTH = 5'b10000;

  localparam string TOPO_MESH  = "MESH";
  localparam string TOPO_TORUS = "TORUS";
  localparam string ROUTE_XY   = "XY";
  localparam string ROUTE_YX   = "YX";

  typedef struct packed {
    logic [4:0] dp;
    logic [4:0] lk;
  } cache_ent_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lkh_route_if.sv
// Flit-in / result-out handshake bundle of the look-ahead route unit.
interface lkh_route_if #(
  parameter int XW = 2,
  parameter int YW = 2,
  parameter int VW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic          in_hdr;
  logic          in_tail;
  logic [VW-1:0] in_vc;
  logic [XW-1:0] in_dest_x;
  logic [YW-1:0] in_dest_y;
  logic [4:0]    in_destport;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vc;
  logic [4:0]    out_destport;
  logic [4:0]    out_lkdestport;
  logic          out_tail;

  modport master (
    output in_valid, in_hdr, in_tail, in_vc, in_dest_x, in_dest_y, in_destport, out_ready,
    input  in_ready, out_valid, out_vc, out_destport, out_lkdestport, out_tail
  );

  modport slave (
    input  in_valid, in_hdr, in_tail, in_vc, in_dest_x, in_dest_y, in_destport, out_ready,
    output in_ready, out_valid, out_vc, out_destport, out_lkdestport, out_tail
  );
endinterface

// File: rtl/lkh_next_port_calc.sv
// Combinational look-ahead: neighbour coordinates from the current output port,
// then the dimension-ordered (XY/YX) port that neighbour will pick.
module lkh_next_port_calc
  import lkh_route_pkg::*;
#(
  parameter int    NX         = 4,
  parameter int    NY         = 4,
  parameter string TOPOLOGY   = TOPO_MESH,
  parameter string ROUTE_NAME = ROUTE_XY,
  parameter int    XW         = clog2_min1(NX),
  parameter int    YW         = clog2_min1(NY)
) (
  input  logic [XW-1:0] cur_x,
  input  logic [YW-1:0] cur_y,
  input  logic [XW-1:0] dest_x,
  input  logic [YW-1:0] dest_y,
  input  logic [4:0]    destport,
  output logic [4:0]    lkdestport
);

  localparam bit IS_TORUS = (TOPOLOGY == TOPO_TORUS);
  localparam bit IS_YX    = (ROUTE_NAME == ROUTE_YX);
  localparam int XE       = XW + 2;
  localparam int YE       = YW + 2;
  localparam logic [XW-1:0] XMAX = XW'(NX - 1);
  localparam logic [YW-1:0] YMAX = YW'(NY - 1);

  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [XE-1:0] de;
  logic [YE-1:0] ds;
  logic          x_pos, y_pos, x_diff, y_diff;
  logic [4:0]    x_port, y_port;

  always_comb begin
    nx = cur_x;
    ny = cur_y;
    if (destport[1])      nx = (IS_TORUS && cur_x == XMAX) ? '0 : cur_x + 1'b1;
    else if (destport[3]) nx = (IS_TORUS && cur_x == '0) ? XMAX : cur_x - 1'b1;
    else if (destport[2]) ny = (IS_TORUS && cur_y == '0) ? YMAX : cur_y - 1'b1;
    else if (destport[4]) ny = (IS_TORUS && cur_y == YMAX) ? '0 : cur_y + 1'b1;

    // Ring distance going east/south; half the ring or less (tie included) goes that way.
    de = (XE'(dest_x) >= XE'(nx)) ? XE'(dest_x) - XE'(nx)
                                  : XE'(dest_x) + XE'(NX) - XE'(nx);
    ds = (YE'(dest_y) >= YE'(ny)) ? YE'(dest_y) - YE'(ny)
                                  : YE'(dest_y) + YE'(NY) - YE'(ny);
    x_pos = IS_TORUS ? ((de << 1) <= XE'(NX)) : (dest_x > nx);
    y_pos = IS_TORUS ? ((ds << 1) <= YE'(NY)) : (dest_y > ny);
    x_port = x_pos ? P_EAST  : P_WEST;
    y_port = y_pos ? P_SOUTH : P_NORTH;
    x_diff = (dest_x != nx);
    y_diff = (dest_y != ny);

    lkdestport = P_LOCAL;
    if (destport[0])  lkdestport = P_LOCAL;
    else if (IS_YX)   lkdestport = y_diff ? y_port : (x_diff ? x_port : P_LOCAL);
    else              lkdestport = x_diff ? x_port : (y_diff ? y_port : P_LOCAL);
  end

endmodule

// File: rtl/lkh_route_pipe.sv
// Per-VC look-ahead route unit: heads compute a route, body/tail reuse the VC's
// cached route, results leave through a 2-entry FIFO. LKH_ROUTE_CHK_EN adds a sticky protocol checker.
module lkh_route_pipe
  import lkh_route_pkg::*;
#(
  parameter int    NX         = 4,
  parameter int    NY         = 4,
  parameter int    V          = 4,
  parameter string TOPOLOGY   = TOPO_MESH,
  parameter string ROUTE_NAME = ROUTE_XY,
  parameter int    XW         = clog2_min1(NX),
  parameter int    YW         = clog2_min1(NY),
  parameter int    VW         = clog2_min1(V)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] cur_x,
  input  logic [YW-1:0] cur_y,
  lkh_route_if.slave    rif,
  output logic          err
);

  typedef struct packed {
    logic [VW-1:0] vc;
    logic [4:0]    dp;
    logic [4:0]    lk;
    logic          tail;
  } res_t;

  cache_ent_t cache_q [V];
  cache_ent_t cache_d [V];
  res_t       fifo_q [2];
  res_t       fifo_d [2];
  logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;
  logic [4:0] lk_calc;
  cache_ent_t rd_ent;
  res_t       res;

  lkh_next_port_calc #(
    .NX(NX), .NY(NY), .TOPOLOGY(TOPOLOGY), .ROUTE_NAME(ROUTE_NAME), .XW(XW), .YW(YW)
  ) u_calc (
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .dest_x     (rif.in_dest_x),
    .dest_y     (rif.in_dest_y),
    .destport   (rif.in_destport),
    .lkdestport (lk_calc)
  );

  // A head's cache write lands at the accepting edge, so a body one cycle
  // later already reads the new entry from the register.
  always_comb begin
    push     = rif.in_valid & in_ready_q;
    pop      = (cnt_q != 2'd0) & rif.out_ready;
    rd_ent   = cache_q[rif.in_vc];
    res.vc   = rif.in_vc;
    res.tail = rif.in_tail;
    res.dp   = rif.in_hdr ? rif.in_destport : rd_ent.dp;
    res.lk   = rif.in_hdr ? lk_calc         : rd_ent.lk;

    cache_d = cache_q;
    if (push && rif.in_hdr) cache_d[rif.in_vc] = '{dp: rif.in_destport, lk: lk_calc};

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = res;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    cnt_d      = cnt_q + 2'(push) - 2'(pop);
    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < V; i++) cache_q[i] <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      cache_q    <= cache_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign rif.in_ready       = in_ready_q;
  assign rif.out_valid      = (cnt_q != 2'd0);
  assign rif.out_vc         = fifo_q[rd_ptr_q].vc;
  assign rif.out_destport   = fifo_q[rd_ptr_q].dp;
  assign rif.out_lkdestport = fifo_q[rd_ptr_q].lk;
  assign rif.out_tail       = fifo_q[rd_ptr_q].tail;

`ifdef LKH_ROUTE_CHK_EN
  // Open bits only matter to the checker; routing itself always trusts the cache.
  logic [V-1:0] open_q, open_d;
  logic         err_q, err_d;
  logic         vc_open;

  always_comb begin
    vc_open = open_q[rif.in_vc];
    open_d  = open_q;
    if (push) begin
      if (rif.in_hdr)       open_d[rif.in_vc] = ~rif.in_tail;
      else if (rif.in_tail) open_d[rif.in_vc] = 1'b0;
    end
    // Head onto an open VC, or body/tail onto a closed one.
    err_d = err_q | (push & (rif.in_hdr == vc_open));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      open_q <= '0;
      err_q  <= 1'b0;
    end else begin
      open_q <= open_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
